sdram_burst_emu: RTL and testbench



---
 rtl/sdram_burst_emu.sv | 133 +++++++++++++
 tb/tb_sdram_burst_emu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_emu.sv
// SDRAM user-side burst responder backed by on-chip block RAM.
// Ports: clk, rst_n (async, active-low); wr/rd request+ack handshakes;
//   sys_wraddr/sys_rdaddr start addresses (low AW bits used);
//   sdwr_byte/sdrd_byte burst lengths (0 = 512 words);
//   sys_data_in write data, sys_data_out registered read data;
//   sdram_init_done rises INIT_CYCLES clocks after reset release.
module sdram_burst_emu #(
    parameter int AW          = 10,
    parameter int DW          = 16,
    parameter int INIT_CYCLES = 20000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sdram_wr_req,
    input  logic          sdram_rd_req,
    output logic          sdram_wr_ack,
    output logic          sdram_rd_ack,
    input  logic [22:0]   sys_wraddr,
    input  logic [22:0]   sys_rdaddr,
    input  logic [8:0]    sdwr_byte,
    input  logic [8:0]    sdrd_byte,
    input  logic [DW-1:0] sys_data_in,
    output logic [DW-1:0] sys_data_out,
    output logic          sdram_init_done
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR, S_RD_PRE, S_RD, S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   init_cnt_q;
    logic            init_done_q;
    logic [AW-1:0]   ptr_q;
    logic [9:0]      len_q;
    logic [9:0]      cnt_q;
    logic [DW-1:0]   dout_q;
    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic            init_last;
    logic            burst_last;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{sys_wraddr[22:AW], sys_rdaddr[22:AW]};

    assign init_last  = (init_cnt_q == INIT_LAST);
    assign burst_last = (cnt_q == len_q - 10'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next-state logic; write wins when both requests are high
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:   if (init_last) state_d = S_IDLE;
            S_IDLE: begin
                if (sdram_wr_req)      state_d = S_WR;
                else if (sdram_rd_req) state_d = S_RD_PRE;
            end
            S_WR:     if (burst_last) state_d = S_GAP;
            S_RD_PRE: state_d = S_RD;
            S_RD:     if (burst_last) state_d = S_GAP;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs: acks decode straight from state so reset clears them at once
    always_comb begin
        sdram_wr_ack    = (state_q == S_WR);
        sdram_rd_ack    = (state_q == S_RD);
        sdram_init_done = init_done_q;
        sys_data_out    = dout_q;
    end

    // Burst datapath. ptr_q runs one word ahead of the ack on reads so the
    // registered output lines up with the ack it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ptr_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    if (init_last) init_done_q <= 1'b1;
                    else           init_cnt_q  <= init_cnt_q + IW'(1);
                end
                S_IDLE: begin
                    cnt_q <= '0;
                    if (sdram_wr_req) begin
                        ptr_q <= sys_wraddr[AW-1:0];
                        len_q <= {(sdwr_byte == 9'd0), sdwr_byte};
                    end else if (sdram_rd_req) begin
                        ptr_q <= sys_rdaddr[AW-1:0];
                        len_q <= {(sdrd_byte == 9'd0), sdrd_byte};
                    end
                end
                S_WR: begin
                    cnt_q <= cnt_q + 10'd1;
                    ptr_q <= ptr_q + AW'(1);
                end
                S_RD_PRE: begin
                    dout_q <= mem[ptr_q];
                    ptr_q  <= ptr_q + AW'(1);
                end
                S_RD: begin
                    cnt_q <= cnt_q + 10'd1;
                    if (!burst_last) begin
                        dout_q <= mem[ptr_q];
                        ptr_q  <= ptr_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == S_WR) mem[ptr_q] <= sys_data_in;
    end

endmodule

// File: tb/tb_sdram_burst_emu.sv
// Randomized directed bench for sdram_burst_emu against a word-array model.
// Ports of the DUT are all driven/observed; AW=10, INIT_CYCLES=100.
module tb_sdram_burst_emu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_ack;
    logic        rd_ack;
    logic [22:0] wraddr = '0;
    logic [22:0] rdaddr = '0;
    logic [8:0]  wrlen = '0;
    logic [8:0]  rdlen = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [1024];

    sdram_burst_emu #(.AW(10), .DW(16), .INIT_CYCLES(100)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_wr_req    (wr_req),
        .sdram_rd_req    (rd_req),
        .sdram_wr_ack    (wr_ack),
        .sdram_rd_ack    (rd_ack),
        .sys_wraddr      (wraddr),
        .sys_rdaddr      (rdaddr),
        .sdwr_byte       (wrlen),
        .sdrd_byte       (rdlen),
        .sys_data_in     (din),
        .sys_data_out    (dout),
        .sdram_init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for init_done after a release at a negedge; pulse wr_req early
    task automatic wait_init();
        int cnt = 0;
        bit saw = 0;
        while (!init_done && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (cnt == 10) wr_req = 1'b1;
            if (cnt == 13) wr_req = 1'b0;
            if (wr_ack || rd_ack) saw = 1'b1;
        end
        chk("init_latency", cnt, 100);
        chk("init_no_ack", {31'd0, saw}, 0);
    endtask

    // incr=1: data base+k, else random data
    task automatic write_burst(input int a, input int l, input bit incr,
                               input int base);
        int n = 0, idx = 0, first = -1;
        bit done = 0;
        @(negedge clk);
        wraddr = {13'($urandom), 10'(a)};
        wrlen  = 9'(l);
        wr_req = 1'b1;
        while (!done && idx < 1200) begin
            @(negedge clk);
            if (wr_ack) begin
                if (first < 0) first = idx;
                if (rd_ack) chk("wr_rd_overlap", {31'd0, rd_ack}, 0);
                wr_req = 1'b0;
                wraddr = 23'($urandom);
                wrlen  = 9'($urandom);
                din    = incr ? 16'(base + n) : 16'($urandom);
                mdl[(a + n) % 1024] = din;
                n++;
            end else if (first >= 0) begin
                done = 1'b1;
                chk("wr_gap_rd", {31'd0, rd_ack}, 0);
            end
            idx++;
        end
        chk("wr_done", {31'd0, done}, 1);
        chk("wr_len", n, l);
        chk("wr_latency", first, 0);
    endtask

    // abort_at>0: assert reset right after that many acks
    task automatic read_burst(input int a, input int l, input int abort_at);
        int n = 0, idx = 0, first = -1;
        bit done = 0;
        logic [15:0] last = '0;
        @(negedge clk);
        rdaddr = {13'($urandom), 10'(a)};
        rdlen  = 9'(l);
        rd_req = 1'b1;
        while (!done && idx < 1200) begin
            @(negedge clk);
            if (rd_ack) begin
                if (first < 0) first = idx;
                if (wr_ack) chk("rd_wr_overlap", {31'd0, wr_ack}, 0);
                rd_req = 1'b0;
                rdaddr = 23'($urandom);
                rdlen  = 9'($urandom);
                last = mdl[(a + n) % 1024];
                chk("rd_data", {16'd0, dout}, {16'd0, last});
                n++;
                if (n == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_rd_ack", {31'd0, rd_ack}, 0);
                    chk("rst_init_done", {31'd0, init_done}, 0);
                    return;
                end
            end else if (first >= 0) begin
                done = 1'b1;
                chk("rd_gap_wr", {31'd0, wr_ack}, 0);
                chk("rd_hold", {16'd0, dout}, {16'd0, last});
            end
            idx++;
        end
        chk("rd_done", {31'd0, done}, 1);
        chk("rd_len", n, l);
        chk("rd_latency", first, 1);
    endtask

    initial begin
        int a, l, off, rl, idx, nw, nr, last_wr, first_rd;
        bit both;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_ack", {31'd0, wr_ack}, 0);
        chk("rst_rd_ack0", {31'd0, rd_ack}, 0);
        chk("rst_dout", {16'd0, dout}, 0);
        chk("rst_done0", {31'd0, init_done}, 0);
        rst_n = 1'b1;
        wait_init();

        // Incrementing 256-word write and readback
        write_burst(0, 256, 1'b1, 0);
        read_burst(0, 256, 0);
        chk("inc_word255", {16'd0, mdl[255]}, 32'd255);

        // Wrap at top of memory
        write_burst(10'h3F0, 32, 1'b1, 16'hA000);
        read_burst(10'h3F0, 32, 0);
        read_burst(0, 16, 0);
        chk("wrap_word0", {16'd0, mdl[0]}, 32'hA010);

        // Simultaneous requests: write first, gap, then read
        a = int'($urandom_range(0, 1023));
        @(negedge clk);
        wraddr = {13'($urandom), 10'(a)};
        rdaddr = {13'($urandom), 10'(a)};
        wrlen  = 9'd20;
        rdlen  = 9'd20;
        wr_req = 1'b1;
        rd_req = 1'b1;
        nw = 0; nr = 0; idx = 0; last_wr = -1; first_rd = -1; both = 0;
        while (nr < 20 && idx < 200) begin
            @(negedge clk);
            if (wr_ack && rd_ack) both = 1'b1;
            if (wr_ack) begin
                wr_req = 1'b0;
                din = 16'($urandom);
                mdl[(a + nw) % 1024] = din;
                nw++;
                last_wr = idx;
            end
            if (rd_ack) begin
                rd_req = 1'b0;
                if (first_rd < 0) first_rd = idx;
                chk("both_rd_data", {16'd0, dout},
                    {16'd0, mdl[(a + nr) % 1024]});
                nr++;
            end
            idx++;
        end
        chk("both_overlap", {31'd0, both}, 0);
        chk("both_wr_len", nw, 20);
        chk("both_rd_len", nr, 20);
        chk("both_order", first_rd - last_wr, 4);
        @(negedge clk);
        chk("both_gap", {30'd0, wr_ack, rd_ack}, 0);

        // Length 0 means 512; single-word read
        a = int'($urandom_range(0, 1023));
        write_burst(a, 512, 1'b0, 0);
        read_burst(a, 1, 0);
        read_burst(a, 512, 0);

        // Random short bursts with sub-range readback
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 1023));
            l = int'($urandom_range(1, 64));
            write_burst(a, l, 1'b0, 0);
            off = int'($urandom_range(0, l - 1));
            rl = int'($urandom_range(1, l - off));
            read_burst((a + off) % 1024, rl, 0);
        end

        // Reset mid-read, memory must survive
        write_burst(10'h100, 256, 1'b0, 0);
        read_burst(10'h100, 256, 101);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        read_burst(10'h100, 256, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
